// File: rtl/branch_predictor.sv
// branch_predictor
// Table of saturating counters indexed by PC (bimodal) or PC XOR global
// history (gshare). Lookups return a registered prediction one cycle later;
// resolved branches train the table, shift the history and bump statistics.
module branch_predictor #(
   parameter int ENTRIES   = 64,
   parameter int CNT_BITS  = 2,
   parameter int MODE      = 0,
   parameter int HIST_BITS = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lookup_valid,
   input  logic [31:0]          lookup_pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [HIST_BITS-1:0] pred_hist,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic                 upd_taken,
   input  logic                 upd_pred,
   input  logic [HIST_BITS-1:0] upd_hist,
   output logic [HIST_BITS-1:0] ghr,
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_mispredicts
);

   localparam int IW = $clog2(ENTRIES);

   typedef logic [IW-1:0]        idx_t;
   typedef logic [CNT_BITS-1:0]  cnt_t;
   typedef logic [HIST_BITS-1:0] hist_t;

   localparam cnt_t CNT_MAX  = {CNT_BITS{1'b1}};
   // Weakly not-taken: MSB clear, all lower bits set.
   localparam cnt_t CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};

   // Saturating up/down step of one counter.
   function automatic cnt_t sat_step(input cnt_t c, input logic taken);
      cnt_t r;
      r = c;
      if (taken) begin
         if (c != CNT_MAX) r = c + 1'b1;
      end else begin
         if (c != '0) r = c - 1'b1;
      end
      return r;
   endfunction

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Table index: word index of the PC, optionally hashed with history.
   function automatic idx_t make_idx(input idx_t pc_idx, input hist_t h);
      idx_t hx;
      hx = (MODE != 0) ? idx_t'(h) : '0;
      return pc_idx ^ hx;
   endfunction

   // State
   cnt_t        cnt_q [ENTRIES];
   cnt_t        cnt_d [ENTRIES];
   hist_t       ghr_q, ghr_d;
   logic [31:0] br_q, br_d;
   logic [31:0] mis_q, mis_d;
   logic        pred_valid_q, pred_valid_d;
   logic        pred_taken_q, pred_taken_d;
   hist_t       pred_hist_q, pred_hist_d;

   // Combinational helpers
   idx_t lk_idx;
   idx_t up_idx;
   cnt_t up_new;
   cnt_t lk_cnt;

   // Only the word-index bits of the PCs participate in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[31:IW+2], lookup_pc[1:0],
                             upd_pc[31:IW+2], upd_pc[1:0]};

   // Index generation, counter training value and write-first read of the table.
   always_comb begin
      lk_idx = make_idx(lookup_pc[IW+1:2], ghr_q);
      up_idx = make_idx(upd_pc[IW+1:2], upd_hist);
      up_new = sat_step(cnt_q[up_idx], upd_taken);
      lk_cnt = cnt_q[lk_idx];
      if (upd_valid && (up_idx == lk_idx)) begin
         lk_cnt = up_new;
      end
   end

   // Next-state for table, history, statistics and the prediction register.
   always_comb begin
      cnt_d        = cnt_q;
      ghr_d        = ghr_q;
      br_d         = br_q;
      mis_d        = mis_q;
      pred_valid_d = lookup_valid;
      pred_taken_d = lookup_valid & lk_cnt[CNT_BITS-1];
      pred_hist_d  = lookup_valid ? ghr_q : '0;
      if (upd_valid) begin
         cnt_d[up_idx] = up_new;
         ghr_d         = hist_t'({ghr_q, upd_taken});
         br_d          = sat_inc32(br_q);
         if (upd_pred != upd_taken) begin
            mis_d = sat_inc32(mis_q);
         end
      end
   end

   // Register all state; reset wins over any lookup or update in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
         ghr_q        <= '0;
         br_q         <= '0;
         mis_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_hist_q  <= '0;
      end else begin
         cnt_q        <= cnt_d;
         ghr_q        <= ghr_d;
         br_q         <= br_d;
         mis_q        <= mis_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_hist_q  <= pred_hist_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign pred_hist        = pred_hist_q;
   assign ghr              = ghr_q;
   assign stat_branches    = br_q;
   assign stat_mispredicts = mis_q;

endmodule
